// File: rtl/netcfg_pkg.sv
// Shared definitions for the network-config register slave: register map,
// response/burst encodings, unlock key and channel state types.
// No logic; constants and a byte-strobe merge helper only.
package netcfg_pkg;

    localparam logic [5:0] IDX_HOST_IP      = 6'd0;
    localparam logic [5:0] IDX_BOARD_IP     = 6'd1;
    localparam logic [5:0] IDX_HOST_MAC_HI  = 6'd2;
    localparam logic [5:0] IDX_HOST_MAC_LO  = 6'd3;
    localparam logic [5:0] IDX_BOARD_MAC_HI = 6'd4;
    localparam logic [5:0] IDX_BOARD_MAC_LO = 6'd5;
    localparam logic [5:0] IDX_ID           = 6'd6;
    localparam logic [5:0] IDX_CTRL         = 6'd7;

    localparam logic [31:0] NETCFG_ID   = 32'h4E43_4647;
    localparam logic [31:0] UNLOCK_KEY  = 32'hA5A5_0000;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Replace the bytes of old_w selected by strb with the bytes of new_w.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/netcfg_burst_addr.sv
// Next word index of a burst: FIXED holds, every other burst type increments.
// Purely combinational, zero latency; the index wraps inside 6 bits.
// No handshake; the caller decides when to advance.
module netcfg_burst_addr
    import netcfg_pkg::*;
(
    input  logic [5:0] i_idx,
    input  logic [1:0] i_burst,
    output logic [5:0] o_idx
);

    // Wrap within the 64-word window so no carry ever reaches address bit 8.
    assign o_idx = (i_burst == BURST_FIXED) ? i_idx : i_idx + 6'd1;

endmodule

// File: rtl/axi_slave_netcfg_regs.sv
// AXI-style register slave holding host/board IP+MAC; optional write lock via NETCFG_WR_PROTECT_EN.
// Writes land one cycle after the beat handshake; first read beat one cycle after the address handshake.
// Address channels ready only when their FSM is idle; read data/resp/last held while RD_DATA_READY is low.
module axi_slave_netcfg_regs
    import netcfg_pkg::*;
#(
    parameter logic [31:0] DEF_HOST_IP   = 32'hC0A8_0001,
    parameter logic [31:0] DEF_BOARD_IP  = 32'hC0A8_000A,
    parameter logic [47:0] DEF_HOST_MAC  = 48'h0000_0000_0000,
    parameter logic [47:0] DEF_BOARD_MAC = 48'h0011_2233_4455
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        SLAVE_CLK,
    output logic        SLAVE_RSTN,
    input  logic [1:0]  SLAVE_WR_ADDR_ID,
    input  logic [31:0] SLAVE_WR_ADDR,
    input  logic [7:0]  SLAVE_WR_ADDR_LEN,
    input  logic [1:0]  SLAVE_WR_ADDR_BURST,
    input  logic        SLAVE_WR_ADDR_VALID,
    output logic        SLAVE_WR_ADDR_READY,
    input  logic [31:0] SLAVE_WR_DATA,
    input  logic [3:0]  SLAVE_WR_STRB,
    input  logic        SLAVE_WR_DATA_LAST,
    input  logic        SLAVE_WR_DATA_VALID,
    output logic        SLAVE_WR_DATA_READY,
    output logic [1:0]  SLAVE_WR_BACK_ID,
    output logic [1:0]  SLAVE_WR_BACK_RESP,
    output logic        SLAVE_WR_BACK_VALID,
    input  logic        SLAVE_WR_BACK_READY,
    input  logic [1:0]  SLAVE_RD_ADDR_ID,
    input  logic [31:0] SLAVE_RD_ADDR,
    input  logic [7:0]  SLAVE_RD_ADDR_LEN,
    input  logic [1:0]  SLAVE_RD_ADDR_BURST,
    input  logic        SLAVE_RD_ADDR_VALID,
    output logic        SLAVE_RD_ADDR_READY,
    output logic [1:0]  SLAVE_RD_BACK_ID,
    output logic [31:0] SLAVE_RD_DATA,
    output logic [1:0]  SLAVE_RD_DATA_RESP,
    output logic        SLAVE_RD_DATA_LAST,
    output logic        SLAVE_RD_DATA_VALID,
    input  logic        SLAVE_RD_DATA_READY,
    output logic [31:0] cfg_host_ip,
    output logic [31:0] cfg_board_ip,
    output logic [47:0] cfg_host_mac,
    output logic [47:0] cfg_board_mac,
    output logic        cfg_update
);

    // ---------------- reset synchroniser ----------------
    logic [1:0] r_rst_sync;
    logic       w_rstn;
    logic       r_live;

    // Assert asynchronously, release two clocks after rstn rises.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_rst_sync <= 2'b00;
        else       r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rstn     = r_rst_sync[1];
    assign SLAVE_CLK  = clk;
    assign SLAVE_RSTN = w_rstn;

    // Keeps address READY low during reset and the first cycle after it.
    always_ff @(posedge clk or negedge w_rstn) begin
        if (!w_rstn) r_live <= 1'b0;
        else         r_live <= 1'b1;
    end

    // ---------------- config storage ----------------
    logic [31:0] r_host_ip;
    logic [31:0] r_board_ip;
    logic [47:0] r_host_mac;
    logic [47:0] r_board_mac;
    logic        r_cfg_update;
`ifdef NETCFG_WR_PROTECT_EN
    logic        r_lock;
`endif

    // ---------------- write channel ----------------
    wr_state_t   r_wstate;
    logic [1:0]  r_wid;
    logic [5:0]  r_widx;
    logic [1:0]  r_wburst;
    logic        r_werr;
    logic [5:0]  w_wr_next;
    logic        w_aw_hs;
    logic        w_wr_beat;
    logic        w_wr_err;
    logic [31:0] w_wr_old;
    logic [31:0] w_wr_merged;

    netcfg_burst_addr u_wr_addr (
        .i_idx   (r_widx),
        .i_burst (r_wburst),
        .o_idx   (w_wr_next)
    );

    assign SLAVE_WR_ADDR_READY = (r_wstate == W_IDLE) && r_live;
    assign SLAVE_WR_DATA_READY = (r_wstate == W_DATA);
    assign SLAVE_WR_BACK_VALID = (r_wstate == W_RESP);
    assign SLAVE_WR_BACK_ID    = r_wid;
    assign SLAVE_WR_BACK_RESP  = r_werr ? RESP_SLVERR : RESP_OKAY;

    assign w_aw_hs   = SLAVE_WR_ADDR_VALID && SLAVE_WR_ADDR_READY;
    assign w_wr_beat = SLAVE_WR_DATA_VALID && SLAVE_WR_DATA_READY;

    // Current word under the write pointer, merged with the strobed bytes of the beat.
    always_comb begin
        w_wr_old = '0;
        case (r_widx)
            IDX_HOST_IP:      w_wr_old = r_host_ip;
            IDX_BOARD_IP:     w_wr_old = r_board_ip;
            IDX_HOST_MAC_HI:  w_wr_old = r_host_mac[47:16];
            IDX_HOST_MAC_LO:  w_wr_old = {16'h0, r_host_mac[15:0]};
            IDX_BOARD_MAC_HI: w_wr_old = r_board_mac[47:16];
            IDX_BOARD_MAC_LO: w_wr_old = {16'h0, r_board_mac[15:0]};
            default:          w_wr_old = '0;
        endcase
        w_wr_merged = strb_merge(w_wr_old, SLAVE_WR_DATA, SLAVE_WR_STRB);
    end

    // A beat errors when it targets out-of-range, read-only, or (if locked) config words.
    always_comb begin
        w_wr_err = (r_widx > IDX_CTRL) || (r_widx == IDX_ID);
`ifdef NETCFG_WR_PROTECT_EN
        if (r_lock && (r_widx < IDX_ID)) w_wr_err = 1'b1;
`endif
    end

    // Write FSM: latch the burst, walk the beats until LAST, then hold the response.
    always_ff @(posedge clk or negedge w_rstn) begin
        if (!w_rstn) begin
            r_wstate <= W_IDLE;
            r_wid    <= 2'b00;
            r_widx   <= 6'd0;
            r_wburst <= BURST_INCR;
            r_werr   <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: if (w_aw_hs) begin
                    r_wid    <= SLAVE_WR_ADDR_ID;
                    r_widx   <= SLAVE_WR_ADDR[7:2];
                    r_wburst <= SLAVE_WR_ADDR_BURST;
                    r_werr   <= 1'b0;
                    r_wstate <= W_DATA;
                end
                W_DATA: if (w_wr_beat) begin
                    r_werr <= r_werr | w_wr_err;
                    r_widx <= w_wr_next;
                    if (SLAVE_WR_DATA_LAST) r_wstate <= W_RESP;
                end
                W_RESP: if (SLAVE_WR_BACK_READY) r_wstate <= W_IDLE;
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Config registers take accepted, non-erroring beats; CTRL drives commit and lock.
    always_ff @(posedge clk or negedge w_rstn) begin
        if (!w_rstn) begin
            r_host_ip    <= DEF_HOST_IP;
            r_board_ip   <= DEF_BOARD_IP;
            r_host_mac   <= DEF_HOST_MAC;
            r_board_mac  <= DEF_BOARD_MAC;
            r_cfg_update <= 1'b0;
`ifdef NETCFG_WR_PROTECT_EN
            r_lock       <= 1'b1;
`endif
        end else begin
            r_cfg_update <= w_wr_beat && (r_widx == IDX_CTRL) &&
                            SLAVE_WR_DATA[0] && SLAVE_WR_STRB[0];
            if (w_wr_beat && !w_wr_err) begin
                case (r_widx)
                    IDX_HOST_IP:      r_host_ip          <= w_wr_merged;
                    IDX_BOARD_IP:     r_board_ip         <= w_wr_merged;
                    IDX_HOST_MAC_HI:  r_host_mac[47:16]  <= w_wr_merged;
                    IDX_HOST_MAC_LO:  r_host_mac[15:0]   <= w_wr_merged[15:0];
                    IDX_BOARD_MAC_HI: r_board_mac[47:16] <= w_wr_merged;
                    IDX_BOARD_MAC_LO: r_board_mac[15:0]  <= w_wr_merged[15:0];
                    IDX_CTRL: begin
`ifdef NETCFG_WR_PROTECT_EN
                        // Whole-word compare: only the key (bit0 free) unlocks, anything else locks.
                        r_lock <= ((SLAVE_WR_DATA & ~32'h1) != UNLOCK_KEY);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cfg_host_ip   = r_host_ip;
    assign cfg_board_ip  = r_board_ip;
    assign cfg_host_mac  = r_host_mac;
    assign cfg_board_mac = r_board_mac;
    assign cfg_update    = r_cfg_update;

    // ---------------- read channel ----------------
    rd_state_t   r_rstate;
    logic [1:0]  r_rid;
    logic [5:0]  r_ridx;
    logic [1:0]  r_rburst;
    logic [7:0]  r_rlen;
    logic [7:0]  r_rcnt;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        r_rlast;
    logic [5:0]  w_rd_next;
    logic [5:0]  w_rd_sel;
    logic [31:0] w_rd_word;
    logic        w_rd_err;
    logic        w_ar_hs;

    netcfg_burst_addr u_rd_addr (
        .i_idx   (r_ridx),
        .i_burst (r_rburst),
        .o_idx   (w_rd_next)
    );

    assign SLAVE_RD_ADDR_READY = (r_rstate == R_IDLE) && r_live;
    assign SLAVE_RD_DATA_VALID = (r_rstate == R_DATA);
    assign SLAVE_RD_BACK_ID    = r_rid;
    assign SLAVE_RD_DATA       = r_rdata;
    assign SLAVE_RD_DATA_RESP  = r_rresp;
    assign SLAVE_RD_DATA_LAST  = r_rlast;

    assign w_ar_hs  = SLAVE_RD_ADDR_VALID && SLAVE_RD_ADDR_READY;
    assign w_rd_sel = (r_rstate == R_IDLE) ? SLAVE_RD_ADDR[7:2] : w_rd_next;

    // Word about to be loaded into the read data register (pre-write value on a collision).
    always_comb begin
        w_rd_word = '0;
        w_rd_err  = 1'b0;
        case (w_rd_sel)
            IDX_HOST_IP:      w_rd_word = r_host_ip;
            IDX_BOARD_IP:     w_rd_word = r_board_ip;
            IDX_HOST_MAC_HI:  w_rd_word = r_host_mac[47:16];
            IDX_HOST_MAC_LO:  w_rd_word = {16'h0, r_host_mac[15:0]};
            IDX_BOARD_MAC_HI: w_rd_word = r_board_mac[47:16];
            IDX_BOARD_MAC_LO: w_rd_word = {16'h0, r_board_mac[15:0]};
            IDX_ID:           w_rd_word = NETCFG_ID;
            IDX_CTRL: begin
`ifdef NETCFG_WR_PROTECT_EN
                w_rd_word = {r_lock, 31'h0};
`endif
            end
            default:          w_rd_err  = 1'b1;
        endcase
    end

    // Read FSM: preload beat 0 on the address handshake, load the next beat on each accept.
    always_ff @(posedge clk or negedge w_rstn) begin
        if (!w_rstn) begin
            r_rstate <= R_IDLE;
            r_rid    <= 2'b00;
            r_ridx   <= 6'd0;
            r_rburst <= BURST_INCR;
            r_rlen   <= 8'd0;
            r_rcnt   <= 8'd0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
            r_rlast  <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: if (w_ar_hs) begin
                    r_rid    <= SLAVE_RD_ADDR_ID;
                    r_ridx   <= w_rd_sel;
                    r_rburst <= SLAVE_RD_ADDR_BURST;
                    r_rlen   <= SLAVE_RD_ADDR_LEN;
                    r_rcnt   <= 8'd0;
                    r_rdata  <= w_rd_word;
                    r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
                    r_rlast  <= (SLAVE_RD_ADDR_LEN == 8'd0);
                    r_rstate <= R_DATA;
                end
                R_DATA: if (SLAVE_RD_DATA_READY) begin
                    if (r_rlast) begin
                        r_rstate <= R_IDLE;
                    end else begin
                        r_ridx  <= w_rd_next;
                        r_rcnt  <= r_rcnt + 8'd1;
                        r_rdata <= w_rd_word;
                        r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
                        r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Address bits outside [7:2] and the write LEN field are intentionally not used.
    logic w_unused;
    assign w_unused = ^{SLAVE_WR_ADDR[31:8], SLAVE_WR_ADDR[1:0], SLAVE_WR_ADDR_LEN,
                        SLAVE_RD_ADDR[31:8], SLAVE_RD_ADDR[1:0]};

endmodule

// File: tb/tb_axi_slave_netcfg_regs.sv
// Self-checking bench for axi_slave_netcfg_regs: directed cases plus randomized bursts
// checked against a word-level model of the register map.
// Works with or without NETCFG_WR_PROTECT_EN defined.
module tb_axi_slave_netcfg_regs;

    localparam logic [31:0] DEF_HOST_IP   = 32'hC0A8_0001;
    localparam logic [31:0] DEF_BOARD_IP  = 32'hC0A8_000A;
    localparam logic [47:0] DEF_HOST_MAC  = 48'h0000_0000_0000;
    localparam logic [47:0] DEF_BOARD_MAC = 48'h0011_2233_4455;

    logic        clk = 1'b0;
    logic        rstn;
    logic        SLAVE_CLK, SLAVE_RSTN;
    logic [1:0]  SLAVE_WR_ADDR_ID;
    logic [31:0] SLAVE_WR_ADDR;
    logic [7:0]  SLAVE_WR_ADDR_LEN;
    logic [1:0]  SLAVE_WR_ADDR_BURST;
    logic        SLAVE_WR_ADDR_VALID, SLAVE_WR_ADDR_READY;
    logic [31:0] SLAVE_WR_DATA;
    logic [3:0]  SLAVE_WR_STRB;
    logic        SLAVE_WR_DATA_LAST, SLAVE_WR_DATA_VALID, SLAVE_WR_DATA_READY;
    logic [1:0]  SLAVE_WR_BACK_ID, SLAVE_WR_BACK_RESP;
    logic        SLAVE_WR_BACK_VALID, SLAVE_WR_BACK_READY;
    logic [1:0]  SLAVE_RD_ADDR_ID;
    logic [31:0] SLAVE_RD_ADDR;
    logic [7:0]  SLAVE_RD_ADDR_LEN;
    logic [1:0]  SLAVE_RD_ADDR_BURST;
    logic        SLAVE_RD_ADDR_VALID, SLAVE_RD_ADDR_READY;
    logic [1:0]  SLAVE_RD_BACK_ID;
    logic [31:0] SLAVE_RD_DATA;
    logic [1:0]  SLAVE_RD_DATA_RESP;
    logic        SLAVE_RD_DATA_LAST, SLAVE_RD_DATA_VALID, SLAVE_RD_DATA_READY;
    logic [31:0] cfg_host_ip, cfg_board_ip;
    logic [47:0] cfg_host_mac, cfg_board_mac;
    logic        cfg_update;

    axi_slave_netcfg_regs dut (
        .clk(clk), .rstn(rstn), .SLAVE_CLK(SLAVE_CLK), .SLAVE_RSTN(SLAVE_RSTN),
        .SLAVE_WR_ADDR_ID(SLAVE_WR_ADDR_ID), .SLAVE_WR_ADDR(SLAVE_WR_ADDR),
        .SLAVE_WR_ADDR_LEN(SLAVE_WR_ADDR_LEN), .SLAVE_WR_ADDR_BURST(SLAVE_WR_ADDR_BURST),
        .SLAVE_WR_ADDR_VALID(SLAVE_WR_ADDR_VALID), .SLAVE_WR_ADDR_READY(SLAVE_WR_ADDR_READY),
        .SLAVE_WR_DATA(SLAVE_WR_DATA), .SLAVE_WR_STRB(SLAVE_WR_STRB),
        .SLAVE_WR_DATA_LAST(SLAVE_WR_DATA_LAST), .SLAVE_WR_DATA_VALID(SLAVE_WR_DATA_VALID),
        .SLAVE_WR_DATA_READY(SLAVE_WR_DATA_READY), .SLAVE_WR_BACK_ID(SLAVE_WR_BACK_ID),
        .SLAVE_WR_BACK_RESP(SLAVE_WR_BACK_RESP), .SLAVE_WR_BACK_VALID(SLAVE_WR_BACK_VALID),
        .SLAVE_WR_BACK_READY(SLAVE_WR_BACK_READY), .SLAVE_RD_ADDR_ID(SLAVE_RD_ADDR_ID),
        .SLAVE_RD_ADDR(SLAVE_RD_ADDR), .SLAVE_RD_ADDR_LEN(SLAVE_RD_ADDR_LEN),
        .SLAVE_RD_ADDR_BURST(SLAVE_RD_ADDR_BURST), .SLAVE_RD_ADDR_VALID(SLAVE_RD_ADDR_VALID),
        .SLAVE_RD_ADDR_READY(SLAVE_RD_ADDR_READY), .SLAVE_RD_BACK_ID(SLAVE_RD_BACK_ID),
        .SLAVE_RD_DATA(SLAVE_RD_DATA), .SLAVE_RD_DATA_RESP(SLAVE_RD_DATA_RESP),
        .SLAVE_RD_DATA_LAST(SLAVE_RD_DATA_LAST), .SLAVE_RD_DATA_VALID(SLAVE_RD_DATA_VALID),
        .SLAVE_RD_DATA_READY(SLAVE_RD_DATA_READY),
        .cfg_host_ip(cfg_host_ip), .cfg_board_ip(cfg_board_ip),
        .cfg_host_mac(cfg_host_mac), .cfg_board_mac(cfg_board_mac), .cfg_update(cfg_update)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the six config words plus the lock flag.
    logic [31:0] m_host_ip, m_board_ip;
    logic [47:0] m_host_mac, m_board_mac;
    logic        m_lock;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_host_ip   = DEF_HOST_IP;
        m_board_ip  = DEF_BOARD_IP;
        m_host_mac  = DEF_HOST_MAC;
        m_board_mac = DEF_BOARD_MAC;
`ifdef NETCFG_WR_PROTECT_EN
        m_lock = 1'b1;
`else
        m_lock = 1'b0;
`endif
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic int nxt(input int i, input logic [1:0] b);
        return (b == 2'b00) ? i : (i + 1) % 64;
    endfunction

    task automatic model_read(input int idx, output logic [31:0] d, output logic e);
        d = 32'h0;
        e = 1'b0;
        case (idx)
            0: d = m_host_ip;
            1: d = m_board_ip;
            2: d = m_host_mac[47:16];
            3: d = {16'h0, m_host_mac[15:0]};
            4: d = m_board_mac[47:16];
            5: d = {16'h0, m_board_mac[15:0]};
            6: d = 32'h4E43_4647;
            7: d = {m_lock, 31'h0};
            default: e = 1'b1;
        endcase
    endtask

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                               output logic e, output logic c);
        logic [31:0] mk, t;
        mk = byte_mask(s);
        e  = 1'b0;
        c  = 1'b0;
        if (idx > 7 || idx == 6) begin
            e = 1'b1;
        end else if (idx == 7) begin
            c = d[0] & s[0];
`ifdef NETCFG_WR_PROTECT_EN
            m_lock = ((d & 32'hFFFF_FFFE) != 32'hA5A5_0000);
`endif
        end else if (m_lock) begin
            e = 1'b1;
        end else begin
            case (idx)
                0: m_host_ip  = (m_host_ip  & ~mk) | (d & mk);
                1: m_board_ip = (m_board_ip & ~mk) | (d & mk);
                2: begin t = m_host_mac[47:16];  m_host_mac[47:16]  = (t & ~mk) | (d & mk); end
                3: begin t = {16'h0, m_host_mac[15:0]};  t = (t & ~mk) | (d & mk);
                         m_host_mac[15:0] = t[15:0]; end
                4: begin t = m_board_mac[47:16]; m_board_mac[47:16] = (t & ~mk) | (d & mk); end
                5: begin t = {16'h0, m_board_mac[15:0]}; t = (t & ~mk) | (d & mk);
                         m_board_mac[15:0] = t[15:0]; end
                default: ;
            endcase
        end
    endtask

    task automatic chk_cfg(input string tag);
        chk({tag, "_host_ip"},   cfg_host_ip,   m_host_ip);
        chk({tag, "_board_ip"},  cfg_board_ip,  m_board_ip);
        chk({tag, "_host_mac"},  cfg_host_mac,  m_host_mac);
        chk({tag, "_board_mac"}, cfg_board_mac, m_board_mac);
    endtask

    // Full write burst of nb beats from wd/ws; checks commit pulses, response and live config.
    task automatic do_write(input logic [31:0] addr, input logic [1:0] burst, input int nb,
                            input logic [1:0] id);
        int idx, tmo, dly;
        logic e, c, any_e;
        @(negedge clk);
        SLAVE_WR_ADDR = addr; SLAVE_WR_ADDR_ID = id; SLAVE_WR_ADDR_BURST = burst;
        SLAVE_WR_ADDR_LEN = 8'(nb - 1); SLAVE_WR_ADDR_VALID = 1'b1;
        tmo = 0;
        while (!SLAVE_WR_ADDR_READY && tmo < 50) begin @(negedge clk); tmo++; end
        if (!SLAVE_WR_ADDR_READY) begin
            chk("wr_addr_ready_timeout", SLAVE_WR_ADDR_READY, 1);
            SLAVE_WR_ADDR_VALID = 1'b0;
            return;
        end
        @(posedge clk); #1 SLAVE_WR_ADDR_VALID = 1'b0;
        @(negedge clk);
        idx = addr[7:2];
        any_e = 1'b0;
        for (int b = 0; b < nb; b++) begin
            SLAVE_WR_DATA = wd[b]; SLAVE_WR_STRB = ws[b];
            SLAVE_WR_DATA_LAST = (b == nb - 1); SLAVE_WR_DATA_VALID = 1'b1;
            tmo = 0;
            while (!SLAVE_WR_DATA_READY && tmo < 50) begin @(negedge clk); tmo++; end
            if (!SLAVE_WR_DATA_READY) begin
                chk("wr_data_ready_timeout", SLAVE_WR_DATA_READY, 1);
                SLAVE_WR_DATA_VALID = 1'b0;
                return;
            end
            @(posedge clk); #1 SLAVE_WR_DATA_VALID = 1'b0; SLAVE_WR_DATA_LAST = 1'b0;
            model_write(idx, wd[b], ws[b], e, c);
            any_e |= e;
            idx = nxt(idx, burst);
            @(negedge clk);
            chk("cfg_update_beat", cfg_update, c);
        end
        tmo = 0;
        while (!SLAVE_WR_BACK_VALID && tmo < 50) begin @(negedge clk); tmo++; end
        chk("wr_back_valid", SLAVE_WR_BACK_VALID, 1);
        dly = $urandom % 3;
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            chk("wr_back_valid_hold", SLAVE_WR_BACK_VALID, 1);
        end
        chk("wr_back_resp", SLAVE_WR_BACK_RESP, any_e ? 2'b10 : 2'b00);
        chk("wr_back_id", SLAVE_WR_BACK_ID, id);
        SLAVE_WR_BACK_READY = 1'b1;
        @(posedge clk); #1 SLAVE_WR_BACK_READY = 1'b0;
        @(negedge clk);
        chk("wr_back_valid_drop", SLAVE_WR_BACK_VALID, 0);
        chk("cfg_update_single", cfg_update, 0);
        chk_cfg("wr");
    endtask

    // Full read burst; stall_beat>=0 stalls that beat stall_n cycles, -1 stalls at random.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [1:0] id, input int stall_beat, input int stall_n);
        int idx, tmo, beat, stalls;
        logic held, expv, stall, ee;
        logic [31:0] hd, ed;
        logic [1:0] hr;
        logic hl;
        @(negedge clk);
        SLAVE_RD_DATA_READY = 1'b0;
        SLAVE_RD_ADDR = addr; SLAVE_RD_ADDR_ID = id; SLAVE_RD_ADDR_LEN = len;
        SLAVE_RD_ADDR_BURST = burst; SLAVE_RD_ADDR_VALID = 1'b1;
        tmo = 0;
        while (!SLAVE_RD_ADDR_READY && tmo < 50) begin @(negedge clk); tmo++; end
        if (!SLAVE_RD_ADDR_READY) begin
            chk("rd_addr_ready_timeout", SLAVE_RD_ADDR_READY, 1);
            SLAVE_RD_ADDR_VALID = 1'b0;
            return;
        end
        @(posedge clk); #1 SLAVE_RD_ADDR_VALID = 1'b0;
        idx = addr[7:2];
        beat = 0; tmo = 0; held = 1'b0; expv = 1'b1; stalls = 0;
        hd = '0; hr = '0; hl = 1'b0;
        while (beat <= int'(len) && tmo < 200) begin
            @(negedge clk);
            if (expv) chk("rd_valid_expected", SLAVE_RD_DATA_VALID, 1);
            expv = 1'b0;
            if (!SLAVE_RD_DATA_VALID) begin tmo++; continue; end
            if (held) begin
                chk("rd_stall_data", SLAVE_RD_DATA, hd);
                chk("rd_stall_resp", SLAVE_RD_DATA_RESP, hr);
                chk("rd_stall_last", SLAVE_RD_DATA_LAST, hl);
            end
            if (beat == stall_beat) stall = (stalls < stall_n);
            else                    stall = (stall_beat < 0) && ($urandom % 4 == 0);
            if (stall) begin
                SLAVE_RD_DATA_READY = 1'b0;
                held = 1'b1; hd = SLAVE_RD_DATA; hr = SLAVE_RD_DATA_RESP; hl = SLAVE_RD_DATA_LAST;
                stalls++; tmo++; expv = 1'b1;
            end else begin
                model_read(idx, ed, ee);
                chk("rd_data", SLAVE_RD_DATA, ed);
                chk("rd_resp", SLAVE_RD_DATA_RESP, ee ? 2'b10 : 2'b00);
                chk("rd_last", SLAVE_RD_DATA_LAST, beat == int'(len));
                chk("rd_id", SLAVE_RD_BACK_ID, id);
                SLAVE_RD_DATA_READY = 1'b1;
                held = 1'b0;
                beat++;
                idx = nxt(idx, burst);
                expv = (beat <= int'(len));
            end
        end
        if (beat <= int'(len)) chk("rd_beats_timeout", beat, int'(len) + 1);
        @(negedge clk);
        chk("rd_valid_drop", SLAVE_RD_DATA_VALID, 0);
        SLAVE_RD_DATA_READY = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_awready"}, SLAVE_WR_ADDR_READY, 0);
        chk({tag, "_wready"},  SLAVE_WR_DATA_READY, 0);
        chk({tag, "_bvalid"},  SLAVE_WR_BACK_VALID, 0);
        chk({tag, "_arready"}, SLAVE_RD_ADDR_READY, 0);
        chk({tag, "_rvalid"},  SLAVE_RD_DATA_VALID, 0);
        chk({tag, "_update"},  cfg_update, 0);
        chk({tag, "_rstn"},    SLAVE_RSTN, 0);
        chk_cfg(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r32, addr;
        int idx, nb;
        logic e, c;
        rstn = 1'b0;
        SLAVE_WR_ADDR_ID = '0; SLAVE_WR_ADDR = '0; SLAVE_WR_ADDR_LEN = '0; SLAVE_WR_ADDR_BURST = '0;
        SLAVE_WR_ADDR_VALID = 1'b0; SLAVE_WR_DATA = '0; SLAVE_WR_STRB = '0;
        SLAVE_WR_DATA_LAST = 1'b0; SLAVE_WR_DATA_VALID = 1'b0; SLAVE_WR_BACK_READY = 1'b0;
        SLAVE_RD_ADDR_ID = '0; SLAVE_RD_ADDR = '0; SLAVE_RD_ADDR_LEN = '0; SLAVE_RD_ADDR_BURST = '0;
        SLAVE_RD_ADDR_VALID = 1'b0; SLAVE_RD_DATA_READY = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        chk_reset_state("reset");
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_awready", SLAVE_WR_ADDR_READY, 1);
        chk("post_reset_arready", SLAVE_RD_ADDR_READY, 1);

        // Default map read-back.
        do_read(32'h0000_0000, 8'd5, 2'b01, 2'd1, 99, 0);

`ifdef NETCFG_WR_PROTECT_EN
        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        do_write(32'h0000_0000, 2'b01, 1, 2'd0);
        chk("locked_host_ip", cfg_host_ip, DEF_HOST_IP);
        wd[0] = 32'hA5A5_0000; ws[0] = 4'hF;
        do_write(32'h0000_001C, 2'b01, 1, 2'd0);
`endif

        wd[0] = 32'h0A00_0002; ws[0] = 4'hF;
        wd[1] = 32'h0A00_0003; ws[1] = 4'hF;
        do_write(32'h0000_0000, 2'b01, 2, 2'd2);
        chk("dir_host_ip", cfg_host_ip, 32'h0A00_0002);
        chk("dir_board_ip", cfg_board_ip, 32'h0A00_0003);

        wd[0] = 32'h0000_0011; ws[0] = 4'h1;
        wd[1] = 32'h0000_0022; ws[1] = 4'h1;
        do_write(32'h0000_0008, 2'b00, 2, 2'd3);
        chk("dir_host_mac", cfg_host_mac, 48'h0000_0022_0000);

        do_read(32'h0000_0018, 8'd0, 2'b01, 2'd0, 99, 0);
        do_read(32'h0000_0040, 8'd0, 2'b01, 2'd1, 99, 0);
        do_read(32'hFFFF_FFFC, 8'd2, 2'b01, 2'd2, 99, 0);
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        do_write(32'h0000_0040, 2'b01, 1, 2'd1);
        wd[0] = 32'h0000_0001; ws[0] = 4'hF;
        do_write(32'h0000_001C, 2'b01, 1, 2'd0);

        do_read(32'h0000_0000, 8'd5, 2'b01, 2'd3, 2, 5);

        // Randomized bursts against the model.
        for (int t = 0; t < 80; t++) begin
            r32 = $urandom;
            idx = ($urandom % 8 == 0) ? int'($urandom % 64) : int'($urandom % 9);
            addr = {r32[31:8], 6'(idx), r32[1:0]};
            if ($urandom % 2 == 1) begin
                nb = 1 + $urandom % 4;
                for (int b = 0; b < nb; b++) begin
                    wd[b] = $urandom;
                    ws[b] = 4'($urandom);
                    if ($urandom % 6 == 0) wd[b] = 32'hA5A5_0000 | 32'($urandom % 2);
                end
                do_write(addr, 2'($urandom), nb, 2'($urandom));
            end else begin
                do_read(addr, 8'($urandom % 4), 2'($urandom), 2'($urandom), -1, 0);
            end
        end

        // Reset in the middle of a read burst and a write burst.
        @(negedge clk);
        SLAVE_RD_ADDR = 32'h0; SLAVE_RD_ADDR_LEN = 8'd7; SLAVE_RD_ADDR_BURST = 2'b01;
        SLAVE_RD_ADDR_VALID = 1'b1; SLAVE_RD_DATA_READY = 1'b0;
        SLAVE_WR_ADDR = 32'h0; SLAVE_WR_ADDR_LEN = 8'd3; SLAVE_WR_ADDR_BURST = 2'b01;
        SLAVE_WR_ADDR_VALID = 1'b1;
        @(posedge clk); #1 SLAVE_RD_ADDR_VALID = 1'b0; SLAVE_WR_ADDR_VALID = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid_before", SLAVE_RD_DATA_VALID, 1);
        SLAVE_WR_DATA = 32'h0102_0304; SLAVE_WR_STRB = 4'hF; SLAVE_WR_DATA_LAST = 1'b0;
        SLAVE_WR_DATA_VALID = 1'b1;
        @(posedge clk); #1 SLAVE_WR_DATA_VALID = 1'b0;
        model_write(0, 32'h0102_0304, 4'hF, e, c);
        @(negedge clk);
        chk("midrst_host_ip_before", cfg_host_ip, m_host_ip);
        rstn = 1'b0;
        #1;
        model_reset();
        chk_reset_state("midrst");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("after_rst_awready", SLAVE_WR_ADDR_READY, 1);
        chk("after_rst_arready", SLAVE_RD_ADDR_READY, 1);
        chk("after_rst_wready", SLAVE_WR_DATA_READY, 0);
        chk("after_rst_bvalid", SLAVE_WR_BACK_VALID, 0);
        chk("after_rst_rvalid", SLAVE_RD_DATA_VALID, 0);
        do_read(32'h0000_0000, 8'd7, 2'b01, 2'd2, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
